// File: rtl/pico_mailbox_fifo.sv
// Dual-channel byte mailbox between two kcpsm6 cores: channel AB (A->B) and BA (B->A),
// each exposed through a four-port window (data, status/control, rx count, tx free).

module pico_mailbox_chan #(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_req,
    input  logic [7:0]    push_data,
    input  logic          pop_req,
    input  logic          flush,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf_evt,
    output logic          unf_evt
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign push_ok_s = push_req & ~full & ~flush;
    assign pop_ok_s  = pop_req & ~empty & ~flush;
    assign ovf_evt   = push_req & full;
    // A pop racing a flush is absorbed by the flush rather than reported as underflow.
    assign unf_evt   = pop_req & empty & ~flush;
    assign head      = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; both requests are judged on pre-edge count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are left as-is on reset and hidden by the empty check.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

module pico_mailbox_fifo #(
    parameter int         DEPTH  = 8,
    parameter logic [7:0] BASE_A = 8'h10,
    parameter logic [7:0] BASE_B = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_port_id,
    input  logic [7:0] a_out_port,
    input  logic       a_write_strobe,
    input  logic       a_read_strobe,
    output logic [7:0] a_in_port,
    output logic       a_rx_ready,
    input  logic [7:0] b_port_id,
    input  logic [7:0] b_out_port,
    input  logic       b_write_strobe,
    input  logic       b_read_strobe,
    output logic [7:0] b_in_port,
    output logic       b_rx_ready
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [7:0] stat_byte(
        input logic tx_full,
        input logic rx_empty,
        input logic tx_empty,
        input logic rx_full,
        input logic tx_ovf,
        input logic rx_unf
    );
        return {2'b00, rx_unf, tx_ovf, rx_full, tx_empty, rx_empty, tx_full};
    endfunction

    logic          a_hit_s, b_hit_s;
    logic [1:0]    a_off_s, b_off_s;
    logic          a_push_s, b_push_s, a_pop_s, b_pop_s;
    logic          a_ctrl_s, b_ctrl_s, a_flush_s, b_flush_s, a_clr_s, b_clr_s;
    logic [7:0]    ab_head_s, ba_head_s;
    logic [CW-1:0] ab_count_s, ba_count_s;
    logic          ab_full_s, ab_empty_s, ba_full_s, ba_empty_s;
    logic          ab_ovf_s, ab_unf_s, ba_ovf_s, ba_unf_s;
    logic          a_ovf_q, a_ovf_d, a_unf_q, a_unf_d;
    logic          b_ovf_q, b_ovf_d, b_unf_q, b_unf_d;

    assign a_hit_s   = (a_port_id[7:2] == BASE_A[7:2]);
    assign b_hit_s   = (b_port_id[7:2] == BASE_B[7:2]);
    assign a_off_s   = a_port_id[1:0];
    assign b_off_s   = b_port_id[1:0];
    assign a_push_s  = a_hit_s & a_write_strobe & (a_off_s == 2'd0);
    assign b_push_s  = b_hit_s & b_write_strobe & (b_off_s == 2'd0);
    assign a_pop_s   = a_hit_s & a_read_strobe & (a_off_s == 2'd0);
    assign b_pop_s   = b_hit_s & b_read_strobe & (b_off_s == 2'd0);
    assign a_ctrl_s  = a_hit_s & a_write_strobe & (a_off_s == 2'd1);
    assign b_ctrl_s  = b_hit_s & b_write_strobe & (b_off_s == 2'd1);
    assign a_clr_s   = a_ctrl_s & a_out_port[0];
    assign b_clr_s   = b_ctrl_s & b_out_port[0];
    assign a_flush_s = a_ctrl_s & a_out_port[1];
    assign b_flush_s = b_ctrl_s & b_out_port[1];

    pico_mailbox_chan #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ab (
        .clk       (clk),
        .reset     (reset),
        .push_req  (a_push_s),
        .push_data (a_out_port),
        .pop_req   (b_pop_s),
        .flush     (a_flush_s),
        .head      (ab_head_s),
        .count     (ab_count_s),
        .full      (ab_full_s),
        .empty     (ab_empty_s),
        .ovf_evt   (ab_ovf_s),
        .unf_evt   (ab_unf_s)
    );

    pico_mailbox_chan #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ba (
        .clk       (clk),
        .reset     (reset),
        .push_req  (b_push_s),
        .push_data (b_out_port),
        .pop_req   (a_pop_s),
        .flush     (b_flush_s),
        .head      (ba_head_s),
        .count     (ba_count_s),
        .full      (ba_full_s),
        .empty     (ba_empty_s),
        .ovf_evt   (ba_ovf_s),
        .unf_evt   (ba_unf_s)
    );

    // Sticky error flags: A owns AB overflow and BA underflow, B the mirror image.
    always_comb begin
        a_ovf_d = a_ovf_q;
        a_unf_d = a_unf_q;
        b_ovf_d = b_ovf_q;
        b_unf_d = b_unf_q;
        if (a_clr_s) begin
            a_ovf_d = 1'b0;
            a_unf_d = 1'b0;
        end else begin
            a_ovf_d = a_ovf_q | ab_ovf_s;
            a_unf_d = a_unf_q | ba_unf_s;
        end
        if (b_clr_s) begin
            b_ovf_d = 1'b0;
            b_unf_d = 1'b0;
        end else begin
            b_ovf_d = b_ovf_q | ba_ovf_s;
            b_unf_d = b_unf_q | ab_unf_s;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_ovf_q <= 1'b0;
            a_unf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            b_unf_q <= 1'b0;
        end else begin
            a_ovf_q <= a_ovf_d;
            a_unf_q <= a_unf_d;
            b_ovf_q <= b_ovf_d;
            b_unf_q <= b_unf_d;
        end
    end

    assign a_rx_ready = ~ba_empty_s;
    assign b_rx_ready = ~ab_empty_s;

    // Side A read mux, combinational from port_id and current state.
    always_comb begin
        a_in_port = 8'h00;
        if (a_hit_s) begin
            case (a_off_s)
                2'd0:    a_in_port = ba_head_s;
                2'd1:    a_in_port = stat_byte(ab_full_s, ba_empty_s, ab_empty_s,
                                               ba_full_s, a_ovf_q, a_unf_q);
                2'd2:    a_in_port = 8'(ba_count_s);
                2'd3:    a_in_port = 8'(DEPTH_C - ab_count_s);
                default: a_in_port = 8'h00;
            endcase
        end else begin
            a_in_port = 8'h00;
        end
    end

    // Side B read mux.
    always_comb begin
        b_in_port = 8'h00;
        if (b_hit_s) begin
            case (b_off_s)
                2'd0:    b_in_port = ab_head_s;
                2'd1:    b_in_port = stat_byte(ba_full_s, ab_empty_s, ba_empty_s,
                                               ab_full_s, b_ovf_q, b_unf_q);
                2'd2:    b_in_port = 8'(ab_count_s);
                2'd3:    b_in_port = 8'(DEPTH_C - ba_count_s);
                default: b_in_port = 8'h00;
            endcase
        end else begin
            b_in_port = 8'h00;
        end
    end
endmodule

// File: tb/tb_pico_mailbox_fifo.sv
// Directed self-checking bench for pico_mailbox_fifo (DEPTH=8, both windows at 8'h10).

module tb_pico_mailbox_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_port_id, a_out_port, a_in_port;
    logic       a_write_strobe, a_read_strobe, a_rx_ready;
    logic [7:0] b_port_id, b_out_port, b_in_port;
    logic       b_write_strobe, b_read_strobe, b_rx_ready;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] v;

    always #5 clk = ~clk;

    pico_mailbox_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .a_port_id      (a_port_id),
        .a_out_port     (a_out_port),
        .a_write_strobe (a_write_strobe),
        .a_read_strobe  (a_read_strobe),
        .a_in_port      (a_in_port),
        .a_rx_ready     (a_rx_ready),
        .b_port_id      (b_port_id),
        .b_out_port     (b_out_port),
        .b_write_strobe (b_write_strobe),
        .b_read_strobe  (b_read_strobe),
        .b_in_port      (b_in_port),
        .b_rx_ready     (b_rx_ready)
    );

    // Bus helpers: all start and end at a falling edge.
    task automatic a_wr(input logic [7:0] addr, input logic [7:0] data);
        a_port_id = addr; a_out_port = data; a_write_strobe = 1'b1;
        @(negedge clk);
        a_write_strobe = 1'b0;
    endtask

    task automatic b_wr(input logic [7:0] addr, input logic [7:0] data);
        b_port_id = addr; b_out_port = data; b_write_strobe = 1'b1;
        @(negedge clk);
        b_write_strobe = 1'b0;
    endtask

    task automatic a_peek(input logic [7:0] addr, output logic [7:0] data);
        a_port_id = addr; #1; data = a_in_port;
    endtask

    task automatic b_peek(input logic [7:0] addr, output logic [7:0] data);
        b_port_id = addr; #1; data = b_in_port;
    endtask

    task automatic a_pop(output logic [7:0] data);
        a_port_id = 8'h10; a_read_strobe = 1'b1; #1; data = a_in_port;
        @(negedge clk);
        a_read_strobe = 1'b0;
    endtask

    task automatic b_pop(output logic [7:0] data);
        b_port_id = 8'h10; b_read_strobe = 1'b1; #1; data = b_in_port;
        @(negedge clk);
        b_read_strobe = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        a_peek(8'h11, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL reset_a_stat got %h exp %h", v, 8'h06); end
        a_peek(8'h13, v);
        checks++; if (v !== 8'h08) begin errors++; $display("FAIL reset_a_free got %h exp %h", v, 8'h08); end
        b_peek(8'h12, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_b_count got %h exp %h", v, 8'h00); end
        checks++; if (a_rx_ready !== 1'b0 || b_rx_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rx_ready got %b%b exp 00", a_rx_ready, b_rx_ready);
        end
        a_peek(8'h20, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL nohit got %h exp %h", v, 8'h00); end
    endtask

    task automatic test_basic;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h07; exp_v[1] = 8'h0A; exp_v[2] = 8'h55;
        for (int i = 0; i < 3; i++) a_wr(8'h10, exp_v[i]);
        b_peek(8'h12, v);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL basic_count got %h exp %h", v, 8'h03); end
        a_peek(8'h13, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL basic_free got %h exp %h", v, 8'h05); end
        for (int i = 0; i < 3; i++) begin
            b_pop(v);
            checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL basic_pop%0d got %h exp %h", i, v, exp_v[i]); end
            checks++; if (b_rx_ready !== (i < 2)) begin
                errors++; $display("FAIL basic_rdy%0d got %b exp %b", i, b_rx_ready, (i < 2));
            end
        end
        b_wr(8'h10, 8'h3C);
        checks++; if (a_rx_ready !== 1'b1) begin errors++; $display("FAIL ba_rdy got %b exp 1", a_rx_ready); end
        a_pop(v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL ba_pop got %h exp %h", v, 8'h3C); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) a_wr(8'h10, 8'(i));
        a_peek(8'h11, v);
        checks++; if (v !== 8'h13) begin errors++; $display("FAIL ovf_a_stat got %h exp %h", v, 8'h13); end
        b_peek(8'h11, v);
        checks++; if (v !== 8'h0C) begin errors++; $display("FAIL ovf_b_stat got %h exp %h", v, 8'h0C); end
        a_peek(8'h13, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL ovf_free got %h exp %h", v, 8'h00); end
        for (int i = 1; i <= 8; i++) begin
            b_pop(v);
            checks++; if (v !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, v, 8'(i)); end
        end
        a_wr(8'h11, 8'h01);
        a_peek(8'h11, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL ovf_clear got %h exp %h", v, 8'h06); end
    endtask

    task automatic test_underflow_wrap;
        b_pop(v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL unf_data got %h exp %h", v, 8'h00); end
        b_peek(8'h11, v);
        checks++; if (v !== 8'h26) begin errors++; $display("FAIL unf_stat got %h exp %h", v, 8'h26); end
        b_peek(8'h12, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL unf_count got %h exp %h", v, 8'h00); end
        b_wr(8'h11, 8'h01);
        b_peek(8'h11, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL unf_clear got %h exp %h", v, 8'h06); end
        for (int i = 0; i < 20; i++) begin
            a_wr(8'h10, 8'(i));
            b_pop(v);
            checks++; if (v !== 8'(i)) begin errors++; $display("FAIL wrap%0d got %h exp %h", i, v, 8'(i)); end
        end
    endtask

    task automatic test_collision;
        for (int i = 0; i < 8; i++) a_wr(8'h10, 8'h80 + 8'(i));
        a_port_id = 8'h10; a_out_port = 8'hEE; a_write_strobe = 1'b1;
        b_pop(v);
        a_write_strobe = 1'b0;
        checks++; if (v !== 8'h80) begin errors++; $display("FAIL full_col_data got %h exp %h", v, 8'h80); end
        b_peek(8'h12, v);
        checks++; if (v !== 8'h07) begin errors++; $display("FAIL full_col_count got %h exp %h", v, 8'h07); end
        a_peek(8'h11, v);
        checks++; if (v !== 8'h12) begin errors++; $display("FAIL full_col_stat got %h exp %h", v, 8'h12); end
        for (int i = 1; i < 8; i++) begin
            b_pop(v);
            checks++; if (v !== 8'h80 + 8'(i)) begin errors++; $display("FAIL full_col_drain%0d got %h exp %h", i, v, 8'h80 + 8'(i)); end
        end
        a_wr(8'h11, 8'h01);
        a_port_id = 8'h10; a_out_port = 8'hEE; a_write_strobe = 1'b1;
        b_pop(v);
        a_write_strobe = 1'b0;
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL empty_col_data got %h exp %h", v, 8'h00); end
        b_peek(8'h11, v);
        checks++; if (v !== 8'h24) begin errors++; $display("FAIL empty_col_stat got %h exp %h", v, 8'h24); end
        b_peek(8'h12, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL empty_col_count got %h exp %h", v, 8'h01); end
        b_peek(8'h10, v);
        checks++; if (v !== 8'hEE) begin errors++; $display("FAIL empty_col_head got %h exp %h", v, 8'hEE); end
        b_wr(8'h11, 8'h01);
        a_port_id = 8'h10; a_out_port = 8'h22; a_write_strobe = 1'b1;
        b_pop(v);
        a_write_strobe = 1'b0;
        checks++; if (v !== 8'hEE) begin errors++; $display("FAIL mid_col_data got %h exp %h", v, 8'hEE); end
        b_peek(8'h12, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL mid_col_count got %h exp %h", v, 8'h01); end
        b_pop(v);
        checks++; if (v !== 8'h22) begin errors++; $display("FAIL mid_col_next got %h exp %h", v, 8'h22); end
    endtask

    task automatic test_flush_reset;
        for (int i = 0; i < 4; i++) a_wr(8'h10, 8'h40 + 8'(i));
        a_wr(8'h11, 8'h02);
        b_peek(8'h12, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL flush_count got %h exp %h", v, 8'h00); end
        checks++; if (b_rx_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b exp 0", b_rx_ready); end
        b_peek(8'h10, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL flush_hidden got %h exp %h", v, 8'h00); end
        a_wr(8'h10, 8'h61);
        a_wr(8'h10, 8'h62);
        a_port_id = 8'h11; a_out_port = 8'h02; a_write_strobe = 1'b1;
        b_pop(v);
        a_write_strobe = 1'b0;
        b_peek(8'h11, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL flush_pop_stat got %h exp %h", v, 8'h06); end
        for (int i = 0; i < 3; i++) b_wr(8'h10, 8'hA0 + 8'(i));
        checks++; if (a_rx_ready !== 1'b1) begin errors++; $display("FAIL prerst_rdy got %b exp 1", a_rx_ready); end
        reset = 1'b1;
        b_port_id = 8'h10; b_out_port = 8'hBB; b_write_strobe = 1'b1;
        @(negedge clk);
        reset = 1'b0; b_write_strobe = 1'b0;
        a_peek(8'h12, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_count got %h exp %h", v, 8'h00); end
        checks++; if (a_rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy got %b exp 0", a_rx_ready); end
        a_peek(8'h11, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL rst_stat got %h exp %h", v, 8'h06); end
    endtask

    initial begin
        reset = 1'b1;
        a_port_id = 8'h00; a_out_port = 8'h00; a_write_strobe = 1'b0; a_read_strobe = 1'b0;
        b_port_id = 8'h00; b_out_port = 8'h00; b_write_strobe = 1'b0; b_read_strobe = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_underflow_wrap();
        test_collision();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
